cnn_cntr_packet_gen: RTL and testbench

- Controller-side generator of the CNTR_PACKET command stream consumed by the CNN PE/POOL/ReLU array decoder.
- Accepts a host byte stream and converts it into buffer-write commands, then sequences the CONV, POOL and OUT phases.
- Sits between the host/DMA byte interface and the CNN_POOL_ReLU top; drives the packet fields as flat registered ports.

---
 rtl/cnn_cntr_packet_gen.sv | 174 +++++++++++++++++
 tb/tb_cnn_cntr_packet_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_cntr_packet_gen.sv
// ---------------------------------------------------------------------------
// cnn_cntr_packet_gen
//
// Builds the CNTR_PACKET command stream for the CNN PE/POOL/ReLU array.
// A started sequence first copies load_len host bytes into the write
// buffers (LOAD). It then sweeps the read buffer (CONV), holds for the
// pooling phase (POOL) and the output phase (OUT), and returns to IDLE
// with a one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        start request, only looked at in IDLE
//   load_len     number of host bytes to load (0..256), latched on start
//   in_valid     host byte valid
//   in_ready     block can take a host byte (combinational from registers)
//   in_data      host byte
//   pk_PE_state  current FSM state (IDLE=0 LOAD=1 CONV=2 POOL=3 OUT=4)
//   pk_wrb_data  write-buffer data
//   pk_wrb_addr  write-buffer address ([7:4] buffer, [3:0] entry)
//   pk_wrb       write-buffer strobe
//   pk_rdb_addr  read-buffer address
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse in the first IDLE cycle after OUT
//
// Host handshake: a byte moves on a rising clock edge where in_valid and
// in_ready are both high. in_valid may be high while in_ready is low
// without effect, and in_data must stay stable while in_valid is high.
// ---------------------------------------------------------------------------
module cnn_cntr_packet_gen #(
  parameter int RD_DEPTH = 16,
  parameter int POOL_CYC = 4,
  parameter int OUT_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] load_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [2:0] pk_PE_state,
  output logic [7:0] pk_wrb_data,
  output logic [7:0] pk_wrb_addr,
  output logic       pk_wrb,
  output logic [3:0] pk_rdb_addr,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CONV = 3'd2,
    ST_POOL = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [8:0]  r_len_q;
  logic [8:0]  r_wr_cnt;
  logic [15:0] r_ph_cnt;
  logic [15:0] w_ph_cnt_next;
  logic        w_phase_last;
  logic        w_xfer;
  logic        r_wrb;
  logic [7:0]  r_wrb_data;
  logic [7:0]  r_wrb_addr;
  logic [3:0]  r_rdb_addr;
  logic        r_busy;
  logic        r_done;

  // Ready only while bytes are still owed; drops as soon as the last one
  // has been taken even if the host keeps in_valid high.
  assign in_ready = (r_state == ST_LOAD) && (r_wr_cnt < r_len_q);
  assign w_xfer   = in_valid && in_ready;

  // Last cycle of the timed phases (CONV/POOL/OUT share one cycle counter).
  always_comb begin
    w_phase_last = 1'b0;
    case (r_state)
      ST_CONV: w_phase_last = (r_ph_cnt == 16'(RD_DEPTH - 1));
      ST_POOL: w_phase_last = (r_ph_cnt == 16'(POOL_CYC - 1));
      ST_OUT:  w_phase_last = (r_ph_cnt == 16'(OUT_CYC - 1));
      default: w_phase_last = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (load_len != 9'd0) ? ST_LOAD : ST_CONV;
        end
      end
      // Leave LOAD one cycle after the final transfer so that the last
      // write strobe is issued while still in LOAD.
      ST_LOAD: begin
        if (r_wr_cnt == r_len_q) begin
          w_next_state = ST_CONV;
        end
      end
      ST_CONV: if (w_phase_last) w_next_state = ST_POOL;
      ST_POOL: if (w_phase_last) w_next_state = ST_OUT;
      ST_OUT:  if (w_phase_last) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Phase counter restarts at 0 on every state change and only advances
  // inside the timed phases.
  always_comb begin
    w_ph_cnt_next = 16'd0;
    if (w_next_state == r_state) begin
      if ((r_state == ST_CONV) || (r_state == ST_POOL) || (r_state == ST_OUT)) begin
        w_ph_cnt_next = r_ph_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_q    <= 9'd0;
      r_wr_cnt   <= 9'd0;
      r_ph_cnt   <= 16'd0;
      r_wrb      <= 1'b0;
      r_wrb_data <= 8'd0;
      r_wrb_addr <= 8'd0;
      r_rdb_addr <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ph_cnt <= w_ph_cnt_next;
      r_busy   <= (w_next_state != ST_IDLE);
      r_done   <= (r_state == ST_OUT) && w_phase_last;
      r_wrb    <= w_xfer;

      if ((r_state == ST_IDLE) && start) begin
        r_len_q  <= load_len;
        r_wr_cnt <= 9'd0;
      end

      // Data/address hold their last value between strobes.
      if (w_xfer) begin
        r_wrb_data <= in_data;
        r_wrb_addr <= r_wr_cnt[7:0];
        r_wr_cnt   <= r_wr_cnt + 9'd1;
      end

      // In CONV the read address mirrors the phase counter; elsewhere 0.
      r_rdb_addr <= (w_next_state == ST_CONV) ? w_ph_cnt_next[3:0] : 4'd0;
    end
  end

  assign pk_PE_state = r_state;
  assign pk_wrb      = r_wrb;
  assign pk_wrb_data = r_wrb_data;
  assign pk_wrb_addr = r_wrb_addr;
  assign pk_rdb_addr = r_rdb_addr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_cnn_cntr_packet_gen.sv
// ---------------------------------------------------------------------------
// tb_cnn_cntr_packet_gen
//
// Lockstep bench. For each sequence a reference timeline is built from the
// phase rules (LOAD until all bytes are taken plus one strobe cycle,
// RD_DEPTH CONV cycles, POOL_CYC POOL cycles, OUT_CYC OUT cycles, then a
// done cycle). Each entry holds the expected outputs for one cycle and the
// inputs to drive in that cycle. The driver pops entries, compares the DUT
// outputs #1 after the rising edge and then applies the inputs.
// ---------------------------------------------------------------------------
module tb_cnn_cntr_packet_gen;

  localparam int RD_DEPTH = 16;
  localparam int POOL_CYC = 4;
  localparam int OUT_CYC  = 1;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] load_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] pk_PE_state;
  logic [7:0] pk_wrb_data;
  logic [7:0] pk_wrb_addr;
  logic       pk_wrb;
  logic [3:0] pk_rdb_addr;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  cnn_cntr_packet_gen #(
    .RD_DEPTH (RD_DEPTH),
    .POOL_CYC (POOL_CYC),
    .OUT_CYC  (OUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_len    (load_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .pk_PE_state (pk_PE_state),
    .pk_wrb_data (pk_wrb_data),
    .pk_wrb_addr (pk_wrb_addr),
    .pk_wrb      (pk_wrb),
    .pk_rdb_addr (pk_rdb_addr),
    .busy        (busy),
    .done        (done)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0] st;
    logic       wrb;
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] rdb;
    logic       busy;
    logic       done;
    logic       rdy;
    logic       vld;   // inputs driven in this cycle
    logic [7:0] din;
    logic       strt;
    logic [8:0] len;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] m_addr;   // last write address/data the packet should hold
  logic [7:0] m_data;
  bit         pat_arr[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // -------------------------------------------------------------------------
  // Reference timeline builders
  // -------------------------------------------------------------------------
  task automatic push_idle(input bit strt, input int len);
    cyc_t e;
    e      = '0;
    e.addr = m_addr;
    e.data = m_data;
    e.strt = strt;
    e.len  = 9'(len);
    e.vld  = 1'($urandom);
    e.din  = 8'($urandom);
    exp_q.push_back(e);
  endtask

  task automatic fill_bytes(input int len);
    byte_q.delete();
    for (int i = 0; i < len; i++) byte_q.push_back(8'($urandom));
  endtask

  // mode 0: in_valid always 1; 1: random; 2: fixed gap pattern then 1.
  // conv_start_at: CONV cycle index in which a stray start is driven (-1 none).
  task automatic build_seq(input int len, input int mode, input int conv_start_at,
                           input bit chain, input int chain_len);
    cyc_t e;
    int   k;
    int   c;
    bit   prev;
    k    = 0;
    c    = 0;
    prev = 1'b0;
    if (len > 0) begin
      forever begin
        e      = '0;
        e.st   = 3'd1;
        e.wrb  = prev;
        e.addr = m_addr;
        e.data = m_data;
        e.busy = 1'b1;
        e.rdy  = (k < len);
        case (mode)
          0:       e.vld = 1'b1;
          1:       e.vld = 1'($urandom_range(0, 1));
          default: e.vld = (c < 7) ? pat_arr[c] : 1'b1;
        endcase
        e.din = (k < len) ? byte_q[k] : 8'($urandom);
        prev  = e.vld && e.rdy;
        if (prev) begin
          m_addr = 8'(k);
          m_data = byte_q[k];
          k++;
        end
        exp_q.push_back(e);
        c++;
        if (!e.rdy) break;
      end
    end
    for (int i = 0; i < RD_DEPTH; i++) begin
      e      = '0;
      e.st   = 3'd2;
      e.rdb  = 4'(i);
      e.addr = m_addr;
      e.data = m_data;
      e.busy = 1'b1;
      e.vld  = 1'($urandom);
      e.din  = 8'($urandom);
      e.strt = (i == conv_start_at);
      e.len  = 9'($urandom_range(0, 256));
      exp_q.push_back(e);
    end
    for (int i = 0; i < POOL_CYC + OUT_CYC; i++) begin
      e      = '0;
      e.st   = (i < POOL_CYC) ? 3'd3 : 3'd4;
      e.addr = m_addr;
      e.data = m_data;
      e.busy = 1'b1;
      e.vld  = 1'($urandom);
      e.din  = 8'($urandom);
      exp_q.push_back(e);
    end
    e      = '0;
    e.done = 1'b1;
    e.addr = m_addr;
    e.data = m_data;
    e.strt = chain;
    e.len  = 9'(chain_len);
    exp_q.push_back(e);
  endtask

  // -------------------------------------------------------------------------
  // Driver: compare one cycle, apply its inputs, step to the next cycle
  // -------------------------------------------------------------------------
  task automatic step_one(input cyc_t e);
    check_val("state",    32'(pk_PE_state), 32'(e.st));
    check_val("wrb",      32'(pk_wrb),      32'(e.wrb));
    check_val("wrb_addr", 32'(pk_wrb_addr), 32'(e.addr));
    check_val("wrb_data", 32'(pk_wrb_data), 32'(e.data));
    check_val("rdb_addr", 32'(pk_rdb_addr), 32'(e.rdb));
    check_val("busy",     32'(busy),        32'(e.busy));
    check_val("done",     32'(done),        32'(e.done));
    check_val("in_ready", 32'(in_ready),    32'(e.rdy));
    start    = e.strt;
    load_len = e.len;
    in_valid = e.vld;
    in_data  = e.din;
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    cyc_t e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      step_one(e);
    end
  endtask

  task automatic run_all();
    run_n(exp_q.size());
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_state"}, 32'(pk_PE_state), 32'd0);
    check_val({tag, "_wrb"},   32'(pk_wrb),      32'd0);
    check_val({tag, "_addr"},  32'(pk_wrb_addr), 32'd0);
    check_val({tag, "_data"},  32'(pk_wrb_data), 32'd0);
    check_val({tag, "_rdb"},   32'(pk_rdb_addr), 32'd0);
    check_val({tag, "_busy"},  32'(busy),        32'd0);
    check_val({tag, "_done"},  32'(done),        32'd0);
    check_val({tag, "_rdy"},   32'(in_ready),    32'd0);
  endtask

  task automatic run_simple(input int len, input int mode);
    fill_bytes(len);
    push_idle(1'b1, len);
    build_seq(len, mode, -1, 1'b0, 0);
    run_all();
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    cyc_t e;
    m_addr   = 8'd0;
    m_data   = 8'd0;
    reset    = 1'b0;
    start    = 1'b0;
    load_len = 9'd0;
    in_valid = 1'b0;
    in_data  = 8'd0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      start    = 1'($urandom);
      load_len = 9'($urandom);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end
    start    = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_idle");
    end

    // Three bytes, continuous valid.
    byte_q = '{8'hA1, 8'hB2, 8'hC3};
    push_idle(1'b1, 3);
    build_seq(3, 0, -1, 1'b0, 0);
    run_all();

    // Back-pressure gap pattern.
    run_simple(4, 2);

    // Full 256-byte load.
    run_simple(256, 0);

    // Zero-length load goes straight to CONV.
    run_simple(0, 1);

    // Stray start during CONV is ignored.
    fill_bytes(5);
    push_idle(1'b1, 5);
    build_seq(5, 1, 5, 1'b0, 0);
    push_idle(1'b0, 0);
    push_idle(1'b0, 0);
    run_all();

    // Start in the done cycle chains a new sequence.
    fill_bytes(2);
    push_idle(1'b1, 2);
    build_seq(2, 0, -1, 1'b1, 3);
    run_all();
    fill_bytes(3);
    build_seq(3, 1, -1, 1'b0, 0);
    run_all();

    // Reset in the middle of LOAD after two of five bytes.
    fill_bytes(5);
    push_idle(1'b1, 5);
    build_seq(5, 0, -1, 1'b0, 0);
    run_n(3);
    e = exp_q.pop_front();
    check_val("abort_pre_wrb",  32'(pk_wrb),      32'(e.wrb));
    check_val("abort_pre_addr", 32'(pk_wrb_addr), 32'(e.addr));
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_val("abort_wrb",   32'(pk_wrb),      32'd0);
    check_val("abort_rdy",   32'(in_ready),    32'd0);
    check_val("abort_state", 32'(pk_PE_state), 32'd0);
    check_val("abort_busy",  32'(busy),        32'd0);
    exp_q.delete();
    m_addr = 8'd0;
    m_data = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) push_idle(1'b0, 0);
    run_all();
    run_simple(5, 1);

    // Random sequences.
    for (int i = 0; i < 6; i++) begin
      run_simple($urandom_range(0, 20), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
